// File: rtl/flash_audio_sequencer_pkg.sv
// rtl/flash_audio_sequencer_pkg.sv - shared states, constants and keyboard codes for the flash audio sequencer
package flash_audio_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_REQ,
    ST_WAIT_DATA
  } seq_state_e;

  localparam logic [3:0] BYTEEN_ALL = 4'hF;

  // ASCII codes keyboard_control decodes into play/pause/direction/restart
  localparam logic [7:0] KEY_E = 8'h45;
  localparam logic [7:0] KEY_D = 8'h44;
  localparam logic [7:0] KEY_B = 8'h42;
  localparam logic [7:0] KEY_F = 8'h46;
  localparam logic [7:0] KEY_R = 8'h52;

endpackage

// File: rtl/flash_addr_counter.sv
// rtl/flash_addr_counter.sv - up/down word-address counter wrapping inside [START_ADDR, END_ADDR]
module flash_addr_counter #(
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              dir_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  logic [ADDR_W-1:0] addr_q, addr_d;

  // load jumps to the clip start as seen from the current direction
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = dir_i ? START_ADDR : END_ADDR;
    end else if (step_i) begin
      if (dir_i) addr_d = (addr_q == END_ADDR) ? START_ADDR : addr_q + ADDR_ONE;
      else       addr_d = (addr_q == START_ADDR) ? END_ADDR : addr_q - ADDR_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) addr_q <= START_ADDR;
    else         addr_q <= addr_d;
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/flash_audio_sequencer.sv
// rtl/flash_audio_sequencer.sv - flash read sequencer emitting two 16-bit audio samples per 32-bit word
module flash_audio_sequencer
  import flash_audio_sequencer_pkg::*;
#(
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
  input  logic              inclk,
  input  logic              reset_n,
  input  logic              sample_tick,
  input  logic              start_read_flash,
  input  logic              direction,
  input  logic              restart,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic              flash_mem_waitrequest,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic [15:0]       audio_sample,
  output logic              sample_valid,
  output logic              flash_read_finished
);

  seq_state_e        state_q, state_d;
  logic              half_q, half_d;
  logic              pend_q, pend_d;
  logic [15:0]       hold_q, hold_d;
  logic [15:0]       sample_q, sample_d;
  logic              valid_q, valid_d;
  logic              fin_q, fin_d;
  logic              apply_restart;
  logic              addr_load, addr_step;
  logic [ADDR_W-1:0] addr;

  // a pending restart waits for any in-flight read to return, then drops its data
  assign apply_restart = pend_q && ((state_q == ST_IDLE) || (state_q == ST_WAIT_TICK) ||
                                    ((state_q == ST_WAIT_DATA) && flash_mem_readdatavalid));

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    pend_d    = pend_q | restart;
    hold_d    = hold_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    fin_d     = 1'b0;
    addr_load = 1'b0;
    addr_step = 1'b0;
    if (apply_restart) begin
      addr_load = 1'b1;
      half_d    = 1'b0;
      pend_d    = restart;
      state_d   = start_read_flash ? ST_WAIT_TICK : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_read_flash) state_d = ST_WAIT_TICK;
        end
        ST_WAIT_TICK: begin
          if (!start_read_flash) begin
            state_d = ST_IDLE;
          end else if (sample_tick) begin
            if (!half_q) begin
              state_d = ST_REQ;
            end else begin
              sample_d  = hold_q;
              valid_d   = 1'b1;
              fin_d     = 1'b1;
              addr_step = 1'b1;
              half_d    = 1'b0;
            end
          end
        end
        ST_REQ: begin
          if (!flash_mem_waitrequest) state_d = ST_WAIT_DATA;
        end
        ST_WAIT_DATA: begin
          // the second half is captured now so a later direction change cannot reorder it
          if (flash_mem_readdatavalid) begin
            sample_d = direction ? flash_mem_readdata[15:0]  : flash_mem_readdata[31:16];
            hold_d   = direction ? flash_mem_readdata[31:16] : flash_mem_readdata[15:0];
            valid_d  = 1'b1;
            half_d   = 1'b1;
            state_d  = start_read_flash ? ST_WAIT_TICK : ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      half_q   <= 1'b0;
      pend_q   <= 1'b0;
      hold_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      pend_q   <= pend_d;
      hold_q   <= hold_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      fin_q    <= fin_d;
    end
  end

  flash_addr_counter #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR)
  ) u_addr (
    .clk_i  (inclk),
    .rst_ni (reset_n),
    .load_i (addr_load),
    .step_i (addr_step),
    .dir_i  (direction),
    .addr_o (addr)
  );

  assign flash_mem_read       = (state_q == ST_REQ);
  assign flash_mem_address    = addr;
  assign flash_mem_byteenable = BYTEEN_ALL;
  assign audio_sample         = sample_q;
  assign sample_valid         = valid_q;
  assign flash_read_finished  = fin_q;

endmodule
